// File: rtl/nco_pkg.sv
// Shared definitions for the NCO sweep master and the PIO slave address map.
package nco_pkg;

    localparam int unsigned NCO_DATA_W   = 32;
    localparam int unsigned NCO_ADDR_W   = 2;
    localparam int unsigned NCO_CNT_W    = 16;
    localparam int unsigned NCO_PHI_ADDR = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DWELL = 2'd2
    } nco_state_e;

    // An Avalon write completes on a cycle with the strobes asserted and no stall.
    function automatic logic nco_accept(input logic cs, input logic write_n, input logic waitreq);
        return cs & ~write_n & ~waitreq;
    endfunction

endpackage

// File: rtl/nco_sweep_dwell_timer.sv
// Loadable down-counter timing the idle gap after each accepted write.
// expired_c is high once one cycle or fewer remains, so a zero load still yields one dwell cycle.
module nco_sweep_dwell_timer
    import nco_pkg::*;
#(
    parameter int unsigned CNT_W = NCO_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic             expired_c
);

    logic [CNT_W-1:0] cnt;

    // Load has priority; otherwise count down while enabled, holding at zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign expired_c = (cnt <= CNT_W'(1));

endmodule

// File: rtl/nco_sweep_master.sv
// Avalon-MM initiator writing a linear phase-increment sweep into the NCO PIO slave.
// Optional feature: define NCO_SWEEP_LOOP_EN to add the `loop` input for continuous sweeping.
module nco_sweep_master
    import nco_pkg::*;
#(
    parameter int unsigned DATA_W   = NCO_DATA_W,
    parameter int unsigned ADDR_W   = NCO_ADDR_W,
    parameter int unsigned CNT_W    = NCO_CNT_W,
    parameter int unsigned PHI_ADDR = NCO_PHI_ADDR
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic [DATA_W-1:0] phi_start,
    input  logic [DATA_W-1:0] phi_step,
    input  logic [CNT_W-1:0]  step_count,
    input  logic [CNT_W-1:0]  dwell,
`ifdef NCO_SWEEP_LOOP_EN
    input  logic              loop,
`endif
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_chipselect,
    output logic              avm_write_n,
    output logic [DATA_W-1:0] avm_writedata,
    input  logic              avm_waitrequest,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] cur_phi
);

    nco_state_e        state, state_nx;
    logic              cs_nx, wn_nx, busy_nx, done_nx, abort, abort_nx;
    logic [DATA_W-1:0] wdata_nx, cur_phi_nx;
    logic [DATA_W-1:0] phi_step_l, phi_step_l_nx;
    logic [CNT_W-1:0]  dwell_l, dwell_l_nx;
    logic [CNT_W-1:0]  pts_left, pts_left_nx;
`ifdef NCO_SWEEP_LOOP_EN
    logic [DATA_W-1:0] phi_start_l, phi_start_l_nx;
    logic [CNT_W-1:0]  step_count_l, step_count_l_nx;
`endif
    logic              accept_c, timer_load_c, timer_en_c, expired_c;

    assign avm_address = ADDR_W'(PHI_ADDR);
    assign accept_c    = nco_accept(avm_chipselect, avm_write_n, avm_waitrequest);

    nco_sweep_dwell_timer #(.CNT_W(CNT_W)) u_dwell_timer (
        .clk       (clk),
        .reset     (reset),
        .load      (timer_load_c),
        .load_val  (dwell_l),
        .en        (timer_en_c),
        .expired_c (expired_c)
    );

    // State, bus drive and sweep bookkeeping registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            avm_chipselect <= 1'b0;
            avm_write_n    <= 1'b1;
            avm_writedata  <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            cur_phi        <= '0;
            abort          <= 1'b0;
            phi_step_l     <= '0;
            dwell_l        <= '0;
            pts_left       <= '0;
`ifdef NCO_SWEEP_LOOP_EN
            phi_start_l    <= '0;
            step_count_l   <= '0;
`endif
        end else begin
            state          <= state_nx;
            avm_chipselect <= cs_nx;
            avm_write_n    <= wn_nx;
            avm_writedata  <= wdata_nx;
            busy           <= busy_nx;
            done           <= done_nx;
            cur_phi        <= cur_phi_nx;
            abort          <= abort_nx;
            phi_step_l     <= phi_step_l_nx;
            dwell_l        <= dwell_l_nx;
            pts_left       <= pts_left_nx;
`ifdef NCO_SWEEP_LOOP_EN
            phi_start_l    <= phi_start_l_nx;
            step_count_l   <= step_count_l_nx;
`endif
        end
    end

    // Next-state and next-output logic for the sweep sequencer.
    always_comb begin
        state_nx      = state;
        cs_nx         = avm_chipselect;
        wn_nx         = avm_write_n;
        wdata_nx      = avm_writedata;
        done_nx       = 1'b0;
        cur_phi_nx    = cur_phi;
        abort_nx      = abort;
        phi_step_l_nx = phi_step_l;
        dwell_l_nx    = dwell_l;
        pts_left_nx   = pts_left;
`ifdef NCO_SWEEP_LOOP_EN
        phi_start_l_nx  = phi_start_l;
        step_count_l_nx = step_count_l;
`endif
        timer_load_c  = 1'b0;
        timer_en_c    = 1'b0;

        unique case (state)
            IDLE: begin
                abort_nx = 1'b0;
                if (start && !stop) begin
                    phi_step_l_nx = phi_step;
                    dwell_l_nx    = dwell;
                    pts_left_nx   = step_count;
                    wdata_nx      = phi_start;
                    cs_nx         = 1'b1;
                    wn_nx         = 1'b0;
                    state_nx      = WRITE;
`ifdef NCO_SWEEP_LOOP_EN
                    phi_start_l_nx  = phi_start;
                    step_count_l_nx = step_count;
`endif
                end
            end
            WRITE: begin
                // A stop seen during a stall is remembered; the write itself always completes.
                if (stop) begin
                    abort_nx = 1'b1;
                end
                if (accept_c) begin
                    cur_phi_nx   = avm_writedata;
                    cs_nx        = 1'b0;
                    wn_nx        = 1'b1;
                    timer_load_c = 1'b1;
                    if (stop || abort) begin
                        abort_nx = 1'b0;
                        state_nx = IDLE;
                    end else begin
                        state_nx = DWELL;
                    end
                end
            end
            DWELL: begin
                timer_en_c = 1'b1;
                if (stop) begin
                    state_nx = IDLE;
                end else if (expired_c) begin
                    if (pts_left != '0) begin
                        pts_left_nx = pts_left - CNT_W'(1);
                        wdata_nx    = avm_writedata + phi_step_l;
                        cs_nx       = 1'b1;
                        wn_nx       = 1'b0;
                        state_nx    = WRITE;
                    end else begin
                        done_nx  = 1'b1;
                        state_nx = IDLE;
`ifdef NCO_SWEEP_LOOP_EN
                        if (loop) begin
                            pts_left_nx = step_count_l;
                            wdata_nx    = phi_start_l;
                            cs_nx       = 1'b1;
                            wn_nx       = 1'b0;
                            state_nx    = WRITE;
                        end
`endif
                    end
                end
            end
            default: begin
                cs_nx    = 1'b0;
                wn_nx    = 1'b1;
                state_nx = IDLE;
            end
        endcase

        busy_nx = (state_nx != IDLE);
    end

endmodule

// File: doc/nco_sweep_master.md
Name: nco_sweep_master

Overview:
- Avalon-MM initiator that drives the NCO phase-increment PIO slave in the same kernel.
- On `start`, it writes a linear frequency sweep into the slave's data register: phi_start, phi_start+phi_step, and so on.
- It waits `dwell` clock cycles between writes.
- This lets the sweep run in hardware, without a NIOS write per frequency point.

Parameters:
- DATA_W, 32, phase word / writedata width
- ADDR_W, 2, Avalon address width
- CNT_W, 16, width of step_count and dwell counters
- PHI_ADDR, 0, slave register address written on every transaction

Ports:
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  single-cycle request to begin a sweep; sampled only in IDLE
- stop  in  1  abort request; honoured in any state
- phi_start  in  DATA_W  first phase increment; latched on accepted start
- phi_step  in  DATA_W  signed-agnostic increment added per point, modulo 2^DATA_W; latched on start
- step_count  in  CNT_W  number of points minus one; latched on start
- dwell  in  CNT_W  idle cycles after each accepted write; latched on start
- avm_address  out  ADDR_W  constant PHI_ADDR
- avm_chipselect  out  1  Avalon chipselect
- avm_write_n  out  1  Avalon write strobe, active low
- avm_writedata  out  DATA_W  phase word being written
- avm_waitrequest  in  1  slave stall; tie to 0 for the zero-wait PIO
- busy  out  1  high in WRITE or DWELL
- done  out  1  one-cycle pulse when the final write's dwell completes
- cur_phi  out  DATA_W  last phase word accepted by the slave

Behaviour:
- Reset is synchronous, active-high, and takes effect in any state, including mid-transaction. Reset values:
  - state IDLE
  - avm_chipselect=0, avm_write_n=1, avm_writedata=0
  - busy=0, done=0, cur_phi=0
  - all counters 0
- States:
  - IDLE: waits for start.
  - WRITE: transaction presented.
  - DWELL: counting down between points.
- Transaction acceptance: a write is accepted on a cycle with avm_chipselect=1, avm_write_n=0 and avm_waitrequest=0.
- IDLE -> WRITE on start=1 with stop=0. Start and stop asserted together in IDLE: stop wins, stay IDLE.
  - Latch the four inputs.
  - Load avm_writedata=phi_start.
  - Set pts_left=step_count.
  - chipselect/write_n are asserted in the cycle after start is sampled (1-cycle latency).
- WRITE: hold chipselect=1, write_n=0 and writedata stable until accepted.
  - On acceptance: cur_phi<=writedata; deassert chipselect/write_n next cycle.
  - Then load dwell_cnt=dwell_latched and go to DWELL.
- DWELL: decrement dwell_cnt each cycle. With dwell=0, DWELL lasts exactly 1 cycle, so back-to-back writes are separated by at least one idle bus cycle.
  - At the expiry cycle, if pts_left != 0: decrement pts_left, writedata<=writedata+phi_step (wraps mod 2^DATA_W, no saturation), go to WRITE.
  - At the expiry cycle, if pts_left == 0: pulse done, go to IDLE.
- Per-point period with waitrequest=0: 1 write cycle + max(dwell,1) cycles.
- start while busy is ignored. Latched parameters cannot change mid-sweep.
- stop handling:
  - stop in DWELL: go to IDLE next cycle, no done pulse.
  - stop in WRITE: the pending transaction is never dropped. Finish it (cur_phi updated), then go to IDLE, no done.
  - stop is remembered via an abort flag if it is a single-cycle pulse during WRITE stall.
- busy deasserts in the same cycle IDLE is entered.
- Total accepted writes per completed sweep = step_count+1. With step_count=0, exactly one write.

Optional Feature:
- Macro NCO_SWEEP_LOOP_EN.
- When defined:
  - Adds input port `loop` (1 bit, sampled at last-point expiry).
  - If loop=1 at the final DWELL expiry: reload writedata=phi_start_latched and pts_left=step_count_latched, go to WRITE, and still pulse done once per pass.
  - stop is the only exit.
- When undefined: no `loop` port; the sweep always ends in IDLE.

Decomposition:
- Shared package nco_pkg holds:
  - state enum (IDLE, WRITE, DWELL)
  - DATA_W/ADDR_W/CNT_W defaults
  - PHI_ADDR constant shared with the PIO slave address map
- One natural sub-module: nco_sweep_dwell_timer, a loadable down-counter with expiry flag.
- FSM, phase accumulator and Avalon drive stay in the top.

Test Plan:
- Basic sweep: phi_start=0x1000, phi_step=0x0100, step_count=3, dwell=2, waitrequest=0 -> four writes of 0x1000, 0x1100, 0x1200, 0x1300, each 3 cycles apart; done pulses once 3 cycles after the last write; cur_phi=0x1300.
- Wrap-around: phi_start=0xFFFFFF80, phi_step=0x100, step_count=1 -> writes 0xFFFFFF80 then 0x00000080.
- Waitrequest stall: waitrequest held high 5 cycles on the 2nd write -> writedata, chipselect and write_n stable for all 6 cycles; exactly one acceptance; no skipped or duplicated value.
- Abort mid-sweep:
  - 1-cycle stop during a stalled WRITE -> that write completes, then IDLE, busy=0, no done.
  - stop in DWELL -> IDLE next cycle.
- Reset during a stalled WRITE -> next cycle chipselect=0, write_n=1, busy=0, cur_phi=0. A later start runs a full fresh sweep.
- Edge cases:
  - step_count=0, dwell=0 -> exactly one write, done 2 cycles after acceptance.
  - start repeated while busy -> ignored.
  - start+stop together in IDLE -> no transaction.
